// File: rtl/regfile_wb_sched_pkg.sv
// Shared definitions for the register-file writeback scheduler: FSM encodings,
// default widths and the hard-wired zero register index.
package regfile_wb_sched_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } wb_state_e;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: starting at ptr, the first requesting source wins.
// Produces a one-hot grant, the winner's index and an any-grant flag.
module regfile_wb_sched_rr_arbiter #(
  parameter int NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [2:0]         grant_idx,
  output logic               grant_any
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers latches.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_SRC; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = 3'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: zero-fills x1..x31 after reset, then round-robins producers
// onto the single RF write port. Optional wb-stage forwarding under `WB_FWD_EN.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_AW  = REG_AW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  input  logic                      hold,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_rd,
  output logic [XLEN-1:0]           rf_wdata,
  output logic                      init_done,
  output logic [2:0]                grant_id
`ifdef WB_FWD_EN
  ,
  input  logic [REG_AW-1:0]         fwd_rs1,
  input  logic [REG_AW-1:0]         fwd_rs2,
  output logic                      fwd_rs1_hit,
  output logic                      fwd_rs2_hit,
  output logic [XLEN-1:0]           fwd_data
`endif
);

  wb_state_e          state;
  logic [REG_AW-1:0]  init_cnt;
  logic [2:0]         rr_ptr;
  logic [NUM_SRC-1:0] grant;
  logic [2:0]         grant_idx;
  logic               grant_any;
  logic               run_ok;
  logic               accept;
  logic [REG_AW-1:0]  sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic [2:0]         rr_next;

  regfile_wb_sched_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req       (src_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // HOLD only differs from RUN by name; the live hold input gates grants directly
  // so acceptance resumes in the very cycle hold drops.
  assign run_ok    = (state != ST_INIT) && !hold;
  assign src_ready = run_ok ? grant : '0;
  assign accept    = run_ok && grant_any;
  assign grant_id  = grant_idx;
  assign rr_next   = (grant_idx == 3'(NUM_SRC - 1)) ? 3'd0 : grant_idx + 3'd1;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_rd   = src_rd[i*REG_AW +: REG_AW];
        sel_data = src_data[i*XLEN +: XLEN];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_cnt  <= REG_AW'(1);
      rr_ptr    <= '0;
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= (state != ST_INIT);
      case (state)
        ST_INIT: begin
          if (!hold) begin
            rf_we    <= 1'b1;
            rf_rd    <= init_cnt;
            rf_wdata <= '0;
            if (init_cnt == '1) state <= ST_RUN;
            else                init_cnt <= init_cnt + REG_AW'(1);
          end else begin
            rf_we <= 1'b0;
          end
        end
        ST_RUN, ST_HOLD: begin
          state <= hold ? ST_HOLD : ST_RUN;
          // Writes to x0 complete the handshake but never reach the register file.
          rf_we <= accept && (sel_rd != REG_AW'(REG_ZERO));
          if (accept) begin
            rf_rd    <= sel_rd;
            rf_wdata <= sel_data;
            rr_ptr   <= rr_next;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef WB_FWD_EN
  // rf_we already excludes x0, so it doubles as "wb stage valid and rd != 0".
  assign fwd_rs1_hit = rf_we && (rf_rd == fwd_rs1);
  assign fwd_rs2_hit = rf_we && (rf_rd == fwd_rs2);
  assign fwd_data    = rf_wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: init sweep, hold, round-robin, x0 writes,
// mid-operation reset and RUN-state hold; forwarding checked when WB_FWD_EN is set.
module tb_regfile_wb_sched;

  localparam int NUM_SRC = 3;
  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*REG_AW-1:0] src_rd;
  logic [NUM_SRC*XLEN-1:0]   src_data;
  logic                      hold;
  logic                      rf_we;
  logic [REG_AW-1:0]         rf_rd;
  logic [XLEN-1:0]           rf_wdata;
  logic                      init_done;
  logic [2:0]                grant_id;
`ifdef WB_FWD_EN
  logic [REG_AW-1:0]         fwd_rs1;
  logic [REG_AW-1:0]         fwd_rs2;
  logic                      fwd_rs1_hit;
  logic                      fwd_rs2_hit;
  logic [XLEN-1:0]           fwd_data;
`endif

  int vectors;
  int miscompares;

  regfile_wb_sched #(.NUM_SRC(NUM_SRC), .XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .hold      (hold),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .init_done (init_done),
    .grant_id  (grant_id)
`ifdef WB_FWD_EN
    ,
    .fwd_rs1     (fwd_rs1),
    .fwd_rs2     (fwd_rs2),
    .fwd_rs1_hit (fwd_rs1_hit),
    .fwd_rs2_hit (fwd_rs2_hit),
    .fwd_data    (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
    src_rd[i*REG_AW +: REG_AW] = rd;
    src_data[i*XLEN +: XLEN]   = data;
  endtask

  logic [REG_AW-1:0] exp_rd  [NUM_SRC];
  logic [XLEN-1:0]   exp_dat [NUM_SRC];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    hold        = 1'b0;
    src_valid   = '0;
    src_rd      = '0;
    src_data    = '0;
`ifdef WB_FWD_EN
    fwd_rs1     = '0;
    fwd_rs2     = '0;
`endif

    // Reset state
    #12;
    check("rst_rf_we",     32'(rf_we),     32'd0);
    check("rst_rf_rd",     32'(rf_rd),     32'd0);
    check("rst_rf_wdata",  rf_wdata,       32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain sweep: x1..x31 written with zero, one per cycle
    for (int k = 1; k <= 31; k++) begin
      tick();
      check($sformatf("sweep_we_%0d", k),   32'(rf_we),     32'd1);
      check($sformatf("sweep_rd_%0d", k),   32'(rf_rd),     32'(k));
      check($sformatf("sweep_data_%0d", k), rf_wdata,       32'd0);
      check($sformatf("sweep_done_%0d", k), 32'(init_done), 32'd0);
    end
    tick();
    check("sweep_init_done", 32'(init_done), 32'd1);
    check("sweep_we_after",  32'(rf_we),     32'd0);

    // Sweep with a 5-cycle hold before x10: finishes on cycle 36
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst2_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("hsweep_rd_%0d", k), 32'(rf_rd), 32'(k));
    end
    hold = 1'b1;
    for (int k = 10; k <= 14; k++) begin
      tick();
      check($sformatf("hsweep_held_we_%0d", k), 32'(rf_we), 32'd0);
    end
    hold = 1'b0;
    for (int k = 15; k <= 36; k++) begin
      tick();
      check($sformatf("hsweep_we_%0d", k), 32'(rf_we), 32'd1);
      check($sformatf("hsweep_rd_%0d", k), 32'(rf_rd), 32'(k - 5));
    end
    check("hsweep_done_36", 32'(init_done), 32'd0);
    tick();
    check("hsweep_done_37", 32'(init_done), 32'd1);

    // Round-robin with all three sources requesting every cycle
    exp_rd[0] = 5'd3; exp_dat[0] = 32'h0000_00A0;
    exp_rd[1] = 5'd4; exp_dat[1] = 32'h0000_00B1;
    exp_rd[2] = 5'd5; exp_dat[2] = 32'h0000_00C2;
    for (int i = 0; i < NUM_SRC; i++) set_src(i, exp_rd[i], exp_dat[i]);
    src_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rr_ready_%0d", c), 32'(src_ready), 32'(3'b001 << (c % 3)));
      check($sformatf("rr_gid_%0d", c),   32'(grant_id),  32'(c % 3));
      tick();
      check($sformatf("rr_we_%0d", c),   32'(rf_we), 32'd1);
      check($sformatf("rr_rd_%0d", c),   32'(rf_rd), 32'(exp_rd[c % 3]));
      check($sformatf("rr_data_%0d", c), rf_wdata,   exp_dat[c % 3]);
      #1;
    end
    src_valid = '0;
    #1;
    check("idle_ready", 32'(src_ready), 32'd0);
    tick();
    check("idle_we", 32'(rf_we), 32'd0);

    // Source 1 writes x0: handshake completes, no RF write, pointer moves to 2
    set_src(1, 5'd0, 32'h0000_DEAD);
    src_valid = 3'b010;
    #1;
    check("x0_ready", 32'(src_ready), 32'b010);
    check("x0_gid",   32'(grant_id),  32'd1);
    tick();
    check("x0_we", 32'(rf_we), 32'd0);
    set_src(1, exp_rd[1], exp_dat[1]);
    src_valid = 3'b111;
    #1;
    check("x0_ptr_gid",   32'(grant_id),  32'd2);
    check("x0_ptr_ready", 32'(src_ready), 32'b100);

    // Reset while source 2's write sits in the wb stage
    tick();
    check("mid_we",   32'(rf_we), 32'd1);
    check("mid_rd",   32'(rf_rd), 32'd5);
    check("mid_data", rf_wdata,   32'h0000_00C2);
    src_valid = '0;
    rst = 1'b1;
    #1;
    check("mid_rst_we",    32'(rf_we),     32'd0);
    check("mid_rst_rd",    32'(rf_rd),     32'd0);
    check("mid_rst_done",  32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("restart_we", 32'(rf_we), 32'd1);
    check("restart_rd", 32'(rf_rd), 32'd1);
    for (int k = 2; k <= 31; k++) tick();
    check("restart_last_rd", 32'(rf_rd), 32'd31);
    tick();
    check("restart_done", 32'(init_done), 32'd1);

    // Hold in RUN: in-flight write retires, grants stop, then resume immediately
    set_src(0, 5'd7, 32'h0000_0077);
    src_valid = 3'b001;
    #1;
    check("hrun_ready0", 32'(src_ready), 32'b001);
    tick();
    hold = 1'b1;
    #1;
    check("hrun_retire_we", 32'(rf_we),     32'd1);
    check("hrun_retire_rd", 32'(rf_rd),     32'd7);
    check("hrun_ready_off", 32'(src_ready), 32'd0);
    tick();
    check("hrun_we_off1", 32'(rf_we), 32'd0);
    tick();
    check("hrun_we_off2", 32'(rf_we), 32'd0);
    hold = 1'b0;
    #1;
    check("hrun_ready_on", 32'(src_ready), 32'b001);
    check("hrun_gid",      32'(grant_id),  32'd0);
    tick();
    check("hrun_we_on", 32'(rf_we), 32'd1);
    check("hrun_rd_on", 32'(rf_rd), 32'd7);

`ifdef WB_FWD_EN
    // Forwarding from the wb stage
    set_src(0, 5'd5, 32'h0000_1234);
    fwd_rs1 = 5'd5;
    fwd_rs2 = 5'd6;
    tick();
    src_valid = '0;
    #1;
    check("fwd_rs1_hit", 32'(fwd_rs1_hit), 32'd1);
    check("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'd0);
    check("fwd_data",    fwd_data,         32'h0000_1234);
    tick();
    check("fwd_rs1_gone", 32'(fwd_rs1_hit), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
